ball_frame_buffer: RTL

BALL_FRAME_BUFFER -- requirements
Module: ball_frame_buffer

---
 rtl/ball_frame_buffer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/ball_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : ball_frame_buffer
//  Purpose  : Collects blob centroids for one camera frame. It keeps the seven
//             largest qualifying blobs in a table sorted by area (descending,
//             ties kept in arrival order). It then publishes them as per-slot
//             x/y outputs with a one-cycle data_valid_out pulse.
//  Ports    : clk_in, rst_in             - clock, synchronous active-high reset
//             frame_start_in/_end_in     - frame delimiting pulses
//             centroid_valid/x/y/area_in - candidate blob stream
//             num_balls_in               - balls expected (latched at start)
//             real_balls_x/y[6:0]        - per-slot coordinates
//             num_balls_out              - latched ball count
//             num_found_out              - qualifying candidates stored (<=7)
//             overflow_out               - more than 7 qualifying candidates
//             data_valid_out             - one-cycle "outputs valid" pulse
//  Revision : 1.0 - initial release
// ============================================================================
module ball_frame_buffer #(
  parameter int unsigned MIN_AREA  = 16,
  parameter logic [10:0] MISSING_X = 11'd0,
  parameter logic [9:0]  MISSING_Y = 10'd0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  input  logic        frame_end_in,
  input  logic        centroid_valid_in,
  input  logic [10:0] centroid_x_in,
  input  logic [9:0]  centroid_y_in,
  input  logic [15:0] centroid_area_in,
  input  logic [2:0]  num_balls_in,
  output logic [10:0] real_balls_x [6:0],
  output logic [9:0]  real_balls_y [6:0],
  output logic [2:0]  num_balls_out,
  output logic [2:0]  num_found_out,
  output logic        overflow_out,
  output logic        data_valid_out
);

  localparam int          DEPTH      = 7;
  localparam logic [15:0] MIN_AREA_W = 16'(MIN_AREA);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_FINALIZE = 2'd2,
    S_EMIT     = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Sorted candidate table (entry 0 = largest area)
  logic [10:0] tab_x_q [DEPTH];
  logic [10:0] tab_x_d [DEPTH];
  logic [9:0]  tab_y_q [DEPTH];
  logic [9:0]  tab_y_d [DEPTH];
  logic [15:0] tab_a_q [DEPTH];
  logic [15:0] tab_a_d [DEPTH];
  logic [2:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  nb_q, nb_d;

  // Registered outputs
  logic [10:0] out_x_q [DEPTH];
  logic [10:0] out_x_d [DEPTH];
  logic [9:0]  out_y_q [DEPTH];
  logic [9:0]  out_y_d [DEPTH];
  logic [2:0]  nb_out_q, nb_out_d;
  logic [2:0]  found_q, found_d;
  logic        ovf_out_q, ovf_out_d;
  logic        dv_q, dv_d;

  logic        qualify;
  logic [2:0]  ins_pos;

  assign qualify = centroid_valid_in && (centroid_area_in >= MIN_AREA_W);

  // Insertion slot = number of stored entries whose area is >= the new one.
  // Because the table is sorted those entries form a prefix, so the last hit
  // wins. A value of 7 means the candidate loses to every entry of a full
  // table and is dropped.
  always_comb begin
    ins_pos = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((3'(i) < count_q) && (tab_a_q[i] >= centroid_area_in)) begin
        ins_pos = 3'(i + 1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tab_x_d   = tab_x_q;
    tab_y_d   = tab_y_q;
    tab_a_d   = tab_a_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    nb_d      = nb_q;
    out_x_d   = out_x_q;
    out_y_d   = out_y_q;
    nb_out_d  = nb_out_q;
    found_d   = found_q;
    ovf_out_d = ovf_out_q;
    // The pulse appears in the cycle following FINALIZE, i.e. while in EMIT
    dv_d      = (state_q == S_FINALIZE);

    case (state_q)
      S_IDLE: begin
        if (frame_start_in) begin
          for (int i = 0; i < DEPTH; i++) begin
            tab_x_d[i] = '0;
            tab_y_d[i] = '0;
            tab_a_d[i] = '0;
          end
          count_d = 3'd0;
          ovf_d   = 1'b0;
          nb_d    = num_balls_in;
          state_d = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (frame_start_in) begin
          // Restart wins over a simultaneous frame end or candidate
          for (int i = 0; i < DEPTH; i++) begin
            tab_x_d[i] = '0;
            tab_y_d[i] = '0;
            tab_a_d[i] = '0;
          end
          count_d = 3'd0;
          ovf_d   = 1'b0;
          nb_d    = num_balls_in;
        end else begin
          if (qualify) begin
            if (ins_pos != 3'd7) begin
              // Shift entries at/after the slot down by one; entry 6 falls off
              for (int i = 1; i < DEPTH; i++) begin
                if (3'(i) > ins_pos) begin
                  tab_x_d[i] = tab_x_q[i-1];
                  tab_y_d[i] = tab_y_q[i-1];
                  tab_a_d[i] = tab_a_q[i-1];
                end
              end
              for (int i = 0; i < DEPTH; i++) begin
                if (3'(i) == ins_pos) begin
                  tab_x_d[i] = centroid_x_in;
                  tab_y_d[i] = centroid_y_in;
                  tab_a_d[i] = centroid_area_in;
                end
              end
            end
            if (count_q == 3'd7) begin
              ovf_d = 1'b1;
            end else begin
              count_d = count_q + 3'd1;
            end
          end
          if (frame_end_in) begin
            state_d = S_FINALIZE;
          end
        end
      end

      S_FINALIZE: begin
        for (int k = 0; k < DEPTH; k++) begin
          if ((3'(k) < count_q) && (3'(k) < nb_q)) begin
            out_x_d[k] = tab_x_q[k];
            out_y_d[k] = tab_y_q[k];
          end else begin
            out_x_d[k] = MISSING_X;
            out_y_d[k] = MISSING_Y;
          end
        end
        found_d   = count_q;
        nb_out_d  = nb_q;
        ovf_out_d = ovf_q;
        state_d   = S_EMIT;
      end

      S_EMIT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        tab_x_q[i] <= '0;
        tab_y_q[i] <= '0;
        tab_a_q[i] <= '0;
        out_x_q[i] <= '0;
        out_y_q[i] <= '0;
      end
      count_q   <= 3'd0;
      ovf_q     <= 1'b0;
      nb_q      <= 3'd0;
      nb_out_q  <= 3'd0;
      found_q   <= 3'd0;
      ovf_out_q <= 1'b0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tab_x_q   <= tab_x_d;
      tab_y_q   <= tab_y_d;
      tab_a_q   <= tab_a_d;
      out_x_q   <= out_x_d;
      out_y_q   <= out_y_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      nb_q      <= nb_d;
      nb_out_q  <= nb_out_d;
      found_q   <= found_d;
      ovf_out_q <= ovf_out_d;
      dv_q      <= dv_d;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      real_balls_x[k] = out_x_q[k];
      real_balls_y[k] = out_y_q[k];
    end
  end

  assign num_balls_out  = nb_out_q;
  assign num_found_out  = found_q;
  assign overflow_out   = ovf_out_q;
  assign data_valid_out = dv_q;

endmodule
`default_nettype wire
